// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding,
// used by the loader, the fetch stage and the testbench.
package imem_pkg;

  localparam int         IMEM_SIZE        = 1024;
  localparam int         IMEM_ADDR_W      = 10;
  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam int         LOADER_TIMEOUT   = 65535;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  function automatic logic len_ok(
    input logic [15:0] n,
    input int          size
  );
    return (n != 16'd0) &&
           ({16'd0, n} <= 32'(size));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host bridge into the loader.
// A byte moves when rx_valid and rx_ready are both high.
interface imem_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/imem_loader_timer.sv
// Inter-byte idle counter; saturates at TIMEOUT and flags expiry
// while parked there.
module imem_loader_timer #(
  parameter  int TIMEOUT = 65535,
  localparam int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [W-1:0] r_cnt;

  assign o_expire = (r_cnt == W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core.
// Define IMEM_LOADER_CSUM_EN to require a trailing mod-256 checksum.
module imem_loader
  import imem_pkg::*;
#(
  parameter int         MEM_SIZE  = IMEM_SIZE,
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE,
  parameter int         TIMEOUT   = LOADER_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  loader_state_e     r_state;
  loader_state_e     w_next;
  logic              r_rdy;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_hold;
  logic              r_err;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_count;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        r_sum;
`endif

  logic              w_acc;
  logic              w_active;
  logic              w_expire;
  logic              w_last;
  logic [15:0]       w_len;

  // No byte is taken in the one-cycle DONE/ERR states.
  assign rx.rx_ready = r_rdy &&
                       (r_state != ST_DONE) &&
                       (r_state != ST_ERR);
  assign w_acc     = rx.rx_valid && rx.rx_ready;
  assign w_active  = (r_state == ST_LEN_HI) ||
                     (r_state == ST_LEN_LO) ||
                     (r_state == ST_DATA)   ||
                     (r_state == ST_CSUM);
  assign w_len     = {r_len_hi, rx.rx_data};
  assign w_last    = (r_count == ADDR_W'(r_len - 16'd1));

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_hold  = r_hold;
  assign load_done = (r_state == ST_DONE);
  assign load_err  = r_err;

  imem_loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_acc || !w_active),
    .i_en     (w_active),
    .o_expire (w_expire)
  );

  // An accepted byte always beats a timer expiring in the same cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc && (rx.rx_data == SYNC_BYTE))
          w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_acc)         w_next = ST_LEN_LO;
        else if (w_expire) w_next = ST_ERR;
      end
      ST_LEN_LO: begin
        if (w_acc)
          w_next = len_ok(w_len, MEM_SIZE) ? ST_DATA : ST_ERR;
        else if (w_expire)
          w_next = ST_ERR;
      end
      ST_DATA: begin
        if (w_acc) begin
          if (w_last) begin
`ifdef IMEM_LOADER_CSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_DONE;
`endif
          end
        end else if (w_expire) begin
          w_next = ST_ERR;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (w_acc)
          w_next = (rx.rx_data == r_sum) ? ST_DONE : ST_ERR;
        else if (w_expire)
          w_next = ST_ERR;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_rdy    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hold   <= 1'b0;
      r_err    <= 1'b0;
      r_len_hi <= '0;
      r_len    <= '0;
      r_count  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
      r_we    <= 1'b0;
      if ((r_state == ST_IDLE) && (w_next == ST_LEN_HI)) begin
        r_hold <= 1'b1;
        r_err  <= 1'b0;
      end
      if (w_next == ST_DONE) r_hold <= 1'b0;
      if (w_next == ST_ERR)  r_err  <= 1'b1;
      if (w_acc && (r_state == ST_LEN_HI))
        r_len_hi <= rx.rx_data;
      if (w_acc && (r_state == ST_LEN_LO)) begin
        r_len   <= w_len;
        r_count <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        r_sum   <= '0;
`endif
      end
      if (w_acc && (r_state == ST_DATA)) begin
        r_we    <= 1'b1;
        r_addr  <= r_count;
        r_wdata <= rx.rx_data;
        r_count <= r_count + ADDR_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
        r_sum   <= r_sum + rx.rx_data;
`endif
      end
    end
  end

endmodule
